// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB digit first.
// Subtract is a + ~b + ~c_in; results and flags update only when the operation completes.
module seq_addsub #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   // state | meaning
   // IDLE  | waiting for start; ready=1
   // RUN   | one digit added per edge, LSB digit first
   // DONE  | result registers valid; done pulse for one cycle

   localparam int N  = WIDTH / DIGIT;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("seq_addsub: DIGIT must satisfy 1 <= DIGIT <= WIDTH and divide WIDTH");
      end
   endgenerate

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [KW-1:0]    k;
   logic             a_msb;
   logic             b_msb;

   logic [DIGIT:0]   digit_sum;
   logic [WIDTH-1:0] res_next;

   always_comb begin
      digit_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      // new digit enters at the top so that after N edges the LSB digit sits at bit 0
      res_next  = (res >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
   end

   assign ready = (state == S_IDLE);
   assign busy  = (state == S_RUN) || (state == S_DONE);
   assign done  = (state == S_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         carry <= 1'b0;
         k     <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         sum   <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= mode ? ~b : b;
                  carry <= mode ? ~c_in : c_in;
                  a_msb <= a[WIDTH-1];
                  b_msb <= mode ? ~b[WIDTH-1] : b[WIDTH-1];
                  res   <= '0;
                  k     <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               res   <= res_next;
               carry <= digit_sum[DIGIT];
               k     <= k + KW'(1);
               if (k == K_LAST) begin
                  sum   <= res_next;
                  c_out <= digit_sum[DIGIT];
                  zero  <= (res_next == '0);
                  ovf   <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter DIGIT, default 4: bits processed per clock cycle; N = WIDTH/DIGIT digit cycles per operation.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request an operation; sampled only while ready=1.
REQ-006 mode  input  1  0 = add (a+b+c_in), 1 = subtract (a-b-c_in).
REQ-007 a  input  WIDTH  first operand, captured when start is accepted.
REQ-008 b  input  WIDTH  second operand, captured when start is accepted.
REQ-009 c_in  input  1  carry-in (add) or borrow-in (subtract), captured when start is accepted.
REQ-010 ready  output  1  high only in IDLE; start is accepted only when it is high.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  one-cycle pulse; the result outputs are valid.
REQ-013 sum  output  WIDTH  result.
REQ-014 c_out  output  1  raw carry out of the MSB; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum equals 0.

Function
REQ-017 Elaboration SHALL fail unless 1 <= DIGIT <= WIDTH and WIDTH mod DIGIT = 0.
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
REQ-019 IDLE: start=1 at an edge SHALL capture a, b' = (mode ? ~b : b), carry = (mode ? ~c_in : c_in) and mode; clear digit counter to 0; go to RUN.
REQ-020 RUN: each edge SHALL add digit k of a, b' and the carry, LSB digit first; it stores DIGIT sum bits and the new carry, then increments k.
REQ-021 RUN SHALL go to DONE at the edge that processes digit N-1; N=1 gives exactly one RUN cycle.
REQ-022 On DONE entry, sum, c_out and zero SHALL be loaded from the working result. ovf SHALL be loaded as (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
REQ-023 done SHALL be high exactly during DONE, i.e. the cycle following the Nth edge after the accepting edge; DONE SHALL return to IDLE at the next edge.
REQ-024 Throughput: consecutive operations SHALL be spaced at least N+2 cycles apart at the accepting edges.
REQ-025 start, a, b, c_in and mode SHALL be ignored while busy=1; a held start is accepted at the first edge with ready=1.
REQ-026 sum, c_out, ovf and zero SHALL hold the previous result throughout RUN; they change only on DONE entry.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH, with no saturation.

Reset
REQ-028 While rst=1, the state SHALL be IDLE, with ready=1, busy=0, done=0, sum=0, c_out=0, ovf=0 and zero=0, independent of clk.
REQ-029 rst asserted during RUN or DONE SHALL abort the operation: no done pulse, no result update. The first edge after rst deasserts SHALL be able to accept start.

Verification (WIDTH=16, DIGIT=4, N=4 unless noted)
REQ-030 Add 0x1234 + 0x4321, c_in=0 -> done 4 edges after the accepting edge; sum=0x5555, c_out=0, ovf=0, zero=0. Repeat with DIGIT=16: done 1 edge after the accepting edge.
REQ-031 Add 0xFFFF + 0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0, zero=1. Add 0x7FFF + 0x0001 -> sum=0x8000, c_out=0, ovf=1.
REQ-032 Sub 0x0005 - 0x0007, c_in=0 -> sum=0xFFFE, c_out=0, ovf=0. Sub 0x7FFF - 0xFFFF -> sum=0x8000, ovf=1.
REQ-033 Hold start=1 throughout with operands changed during RUN -> only the first operands are used; the second operation is accepted the edge after DONE; ready/busy/done timing matches REQ-023.
REQ-034 Assert rst after 2 RUN edges -> outputs go to REQ-028 values immediately with no done pulse; a following add 0x0001 + 0x0001 yields sum=0x0002.
